// File: rtl/match_dispatch_arbiter_pkg.sv
// Shared widths and slot records for match_dispatch_arbiter.
package match_dispatch_arbiter_pkg;

  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_JOB_PE_D   = 4;
  localparam int NUM_MATCH_PE_D = 4;
  localparam int ADDR_WIDTH_D   = 32;
  localparam int LEN_W_D        = 6;
  localparam int JW_D           = clog2w(NUM_JOB_PE_D);
  localparam int MW_D           = clog2w(NUM_MATCH_PE_D);

  typedef struct packed {
    logic [JW_D-1:0]         id;
    logic [7:0]              tag;
    logic [ADDR_WIDTH_D-1:0] head;
    logic [ADDR_WIDTH_D-1:0] hist;
  } mreq_slot_t;

  typedef struct packed {
    logic [7:0]         tag;
    logic [LEN_W_D-1:0] len;
  } resp_slot_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/match_dispatch_arbiter_rr_arbiter.sv
// Round-robin picker: first set bit of req at or after ptr, with wrap.
module rr_arbiter
  import match_dispatch_arbiter_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = W'(k);
      end
    end
  end

endmodule

// File: rtl/match_dispatch_arbiter.sv
// Job-PE <-> match-PE dispatch: one request and one response moved per cycle.
// Define MATCH_DISPATCH_STATS_EN to add grant/stall counters.
module match_dispatch_arbiter
  import match_dispatch_arbiter_pkg::*;
#(
  parameter  int NUM_JOB_PE   = NUM_JOB_PE_D,
  parameter  int NUM_MATCH_PE = NUM_MATCH_PE_D,
  parameter  int ADDR_WIDTH   = ADDR_WIDTH_D,
  parameter  int LEN_W        = LEN_W_D,
  localparam int JW           = clog2w(NUM_JOB_PE),
  localparam int MW           = clog2w(NUM_MATCH_PE)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_JOB_PE-1:0]              i_req_valid,
  output logic [NUM_JOB_PE-1:0]              o_req_ready,
  input  logic [NUM_JOB_PE*8-1:0]            i_req_tag,
  input  logic [NUM_JOB_PE*ADDR_WIDTH-1:0]   i_req_head_addr,
  input  logic [NUM_JOB_PE*ADDR_WIDTH-1:0]   i_req_history_addr,
  output logic [NUM_MATCH_PE-1:0]            o_mreq_valid,
  input  logic [NUM_MATCH_PE-1:0]            i_mreq_ready,
  output logic [NUM_MATCH_PE*JW-1:0]         o_mreq_job_pe_id,
  output logic [NUM_MATCH_PE*8-1:0]          o_mreq_tag,
  output logic [NUM_MATCH_PE*ADDR_WIDTH-1:0] o_mreq_head_addr,
  output logic [NUM_MATCH_PE*ADDR_WIDTH-1:0] o_mreq_history_addr,
  input  logic [NUM_MATCH_PE-1:0]            i_mresp_valid,
  output logic [NUM_MATCH_PE-1:0]            o_mresp_ready,
  input  logic [NUM_MATCH_PE*JW-1:0]         i_mresp_job_pe_id,
  input  logic [NUM_MATCH_PE*8-1:0]          i_mresp_tag,
  input  logic [NUM_MATCH_PE*LEN_W-1:0]      i_mresp_match_len,
  output logic [NUM_JOB_PE-1:0]              o_resp_valid,
  input  logic [NUM_JOB_PE-1:0]              i_resp_ready,
  output logic [NUM_JOB_PE*8-1:0]            o_resp_tag,
  output logic [NUM_JOB_PE*LEN_W-1:0]        o_resp_match_len
`ifdef MATCH_DISPATCH_STATS_EN
  ,
  output logic [31:0]                        o_stat_req_cnt,
  output logic [31:0]                        o_stat_resp_cnt,
  output logic [31:0]                        o_stat_stall_cnt
`endif
);

  // request side
  mreq_slot_t [NUM_MATCH_PE-1:0] mslot;
  mreq_slot_t                    req_rec;
  logic [NUM_MATCH_PE-1:0]       mvld, mfree, tgt_gnt;
  logic [NUM_JOB_PE-1:0]         req_gnt;
  logic [JW-1:0]                 req_ptr, req_idx;
  logic [MW-1:0]                 tgt_ptr, tgt_idx;
  logic                          req_any, tgt_any, req_fire;

  // a full slot being drained this cycle can be refilled on the same edge
  assign mfree = ~mvld | i_mreq_ready;

  rr_arbiter #(.N(NUM_JOB_PE)) u_req_arb (
    .req(i_req_valid), .ptr(req_ptr), .gnt(req_gnt), .idx(req_idx), .any(req_any)
  );

  rr_arbiter #(.N(NUM_MATCH_PE)) u_tgt_arb (
    .req(mfree), .ptr(tgt_ptr), .gnt(tgt_gnt), .idx(tgt_idx), .any(tgt_any)
  );

  assign req_fire    = req_any & tgt_any;
  assign o_req_ready = req_fire ? req_gnt : '0;

  always_comb begin
    req_rec      = '0;
    req_rec.id   = req_idx;
    req_rec.tag  = i_req_tag[int'(req_idx)*8 +: 8];
    req_rec.head = i_req_head_addr[int'(req_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    req_rec.hist = i_req_history_addr[int'(req_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mvld    <= '0;
      req_ptr <= '0;
      tgt_ptr <= '0;
    end else begin
      mvld <= (mvld & ~i_mreq_ready) | (req_fire ? tgt_gnt : '0);
      if (req_fire) begin
        req_ptr <= req_idx + 1'b1;
        tgt_ptr <= tgt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) mslot[tgt_idx] <= req_rec;
  end

  // response side
  resp_slot_t [NUM_JOB_PE-1:0] rslot;
  resp_slot_t                  resp_rec;
  logic [NUM_JOB_PE-1:0]       rvld, rfree, rdst_oh;
  logic [NUM_MATCH_PE-1:0]     cand, resp_gnt;
  logic [MW-1:0]               resp_ptr, resp_idx;
  logic [JW-1:0]               resp_dst;
  logic                        resp_fire;

  assign rfree = ~rvld | i_resp_ready;

  // only responses whose destination can take them compete, so a blocked
  // job PE never stalls the others
  always_comb begin
    cand = '0;
    for (int m = 0; m < NUM_MATCH_PE; m++)
      cand[m] = i_mresp_valid[m] & rfree[i_mresp_job_pe_id[m*JW +: JW]];
  end

  rr_arbiter #(.N(NUM_MATCH_PE)) u_resp_arb (
    .req(cand), .ptr(resp_ptr), .gnt(resp_gnt), .idx(resp_idx), .any(resp_fire)
  );

  assign o_mresp_ready = resp_gnt;

  always_comb begin
    resp_dst     = i_mresp_job_pe_id[int'(resp_idx)*JW +: JW];
    resp_rec     = '0;
    resp_rec.tag = i_mresp_tag[int'(resp_idx)*8 +: 8];
    resp_rec.len = i_mresp_match_len[int'(resp_idx)*LEN_W +: LEN_W];
    rdst_oh      = '0;
    if (resp_fire) rdst_oh[resp_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvld     <= '0;
      resp_ptr <= '0;
    end else begin
      rvld <= (rvld & ~i_resp_ready) | rdst_oh;
      if (resp_fire) resp_ptr <= resp_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_fire) rslot[resp_dst] <= resp_rec;
  end

  // output flattening
  assign o_mreq_valid = mvld;
  assign o_resp_valid = rvld;

  for (genvar j = 0; j < NUM_MATCH_PE; j++) begin : g_mreq_out
    assign o_mreq_job_pe_id[j*JW +: JW]                = mslot[j].id;
    assign o_mreq_tag[j*8 +: 8]                        = mslot[j].tag;
    assign o_mreq_head_addr[j*ADDR_WIDTH +: ADDR_WIDTH]    = mslot[j].head;
    assign o_mreq_history_addr[j*ADDR_WIDTH +: ADDR_WIDTH] = mslot[j].hist;
  end

  for (genvar k = 0; k < NUM_JOB_PE; k++) begin : g_resp_out
    assign o_resp_tag[k*8 +: 8]             = rslot[k].tag;
    assign o_resp_match_len[k*LEN_W +: LEN_W] = rslot[k].len;
  end

`ifdef MATCH_DISPATCH_STATS_EN
  logic [31:0] stat_req_q, stat_resp_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req_q   <= '0;
      stat_resp_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_req_q   <= sat_inc(stat_req_q, req_fire);
      stat_resp_q  <= sat_inc(stat_resp_q, resp_fire);
      stat_stall_q <= sat_inc(stat_stall_q, (|i_req_valid) & ~tgt_any);
    end
  end

  assign o_stat_req_cnt   = stat_req_q;
  assign o_stat_resp_cnt  = stat_resp_q;
  assign o_stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: doc/match_dispatch_arbiter.md
Name: match_dispatch_arbiter

Overview:
- Shares a pool of match PEs among the job PEs.
- Request side: arbitrates job-PE match requests and issues each one to a match PE that has a free request slot.
- Response side: collects match-PE responses and routes each to the job PE named by its job_pe_id.
- Sits between the job-PE array and the match-PE array; one request and one response are moved per cycle.

Parameters:
- NUM_JOB_PE, 4, number of requesting job PEs (power of two); JW = log2(NUM_JOB_PE)
- NUM_MATCH_PE, 4, number of match PEs (power of two); MW = log2(NUM_MATCH_PE)
- ADDR_WIDTH, 32, byte address width
- LEN_W, 6, match-length width (MAX_MATCH_LEN_LOG2+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_req_valid  in  NUM_JOB_PE  per job PE: request valid
- o_req_ready  out  NUM_JOB_PE  per job PE: request accepted (one-hot or zero)
- i_req_tag  in  NUM_JOB_PE*8  flattened tags
- i_req_head_addr  in  NUM_JOB_PE*ADDR_WIDTH  flattened head addresses
- i_req_history_addr  in  NUM_JOB_PE*ADDR_WIDTH  flattened history addresses
- o_mreq_valid  out  NUM_MATCH_PE  per match PE: request slot full
- i_mreq_ready  in  NUM_MATCH_PE  match PE accepts its slot
- o_mreq_job_pe_id  out  NUM_MATCH_PE*JW  originating job PE
- o_mreq_tag  out  NUM_MATCH_PE*8  tag
- o_mreq_head_addr  out  NUM_MATCH_PE*ADDR_WIDTH  head address
- o_mreq_history_addr  out  NUM_MATCH_PE*ADDR_WIDTH  history address
- i_mresp_valid  in  NUM_MATCH_PE  match-PE response valid
- o_mresp_ready  out  NUM_MATCH_PE  response accepted (one-hot or zero)
- i_mresp_job_pe_id  in  NUM_MATCH_PE*JW  destination job PE
- i_mresp_tag  in  NUM_MATCH_PE*8  tag
- i_mresp_match_len  in  NUM_MATCH_PE*LEN_W  match length
- o_resp_valid  out  NUM_JOB_PE  per job PE: response slot full
- i_resp_ready  in  NUM_JOB_PE  job PE consumes its slot
- o_resp_tag  out  NUM_JOB_PE*8  tag
- o_resp_match_len  out  NUM_JOB_PE*LEN_W  match length

Behaviour:
- Reset: all o_mreq_valid/o_resp_valid = 0. All round-robin pointers = 0. Slot data is don't-care (no reset needed). Reset mid-operation drops all buffered requests and responses.
- Request slots: one-entry register per match PE.
  - Slot free this cycle = (empty) OR (full AND i_mreq_ready).
- Request arbitration (combinational):
  - Requester: round-robin over i_req_valid, starting at req_ptr.
  - Target: first free slot searching from tgt_ptr upward, with wrap.
  - Grant only if a requester AND a free slot both exist. Then o_req_ready asserts for exactly that job PE, and the slot loads {id, tag, head, history} on the next edge.
  - After a grant: req_ptr = granted+1 mod NUM_JOB_PE; tgt_ptr = target+1 mod NUM_MATCH_PE. Neither pointer moves without a grant.
- Request latency: accept edge to o_mreq_valid = 1 cycle.
  - Drain and refill of the same slot in one cycle is allowed: full throughput, valid stays 1.
  - A slot with valid=1 holds stable data until i_mreq_ready.
- Response slots: one-entry register per job PE.
  - Slot free = empty OR (full AND i_resp_ready).
- Response arbitration: round-robin over match PEs with i_mresp_valid AND (destination slot free), starting at resp_ptr.
  - The winner gets o_mresp_ready; its {tag, len} loads into slot[job_pe_id].
  - resp_ptr = winner+1 mod NUM_MATCH_PE.
  - A response whose destination slot is blocked does not block other match PEs.
- Response latency: 1 cycle; same drain/refill rule as request slots.
- At most one grant per side per cycle. Requests and responses are independent: both sides may grant in the same cycle.
- Ordering: no ordering guarantee across match PEs; job PEs match responses by tag.
- Fairness: a continuously valid requester is granted within NUM_JOB_PE grants.

Optional Feature:
- MATCH_DISPATCH_STATS_EN defined: adds outputs o_stat_req_cnt (32), o_stat_resp_cnt (32), o_stat_stall_cnt (32).
  - req_cnt: +1 per request grant.
  - resp_cnt: +1 per response grant.
  - stall_cnt: +1 per cycle with any i_req_valid but no free request slot.
  - All counters saturate at 2^32-1 and clear on rst.
- MATCH_DISPATCH_STATS_EN undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package: JW, MW, LEN_W derivations; request-slot and response-slot record typedefs.
- One natural sub-module: rr_arbiter (parameter N). Inputs req[N], ptr; outputs grant one-hot and grant index. Instantiated twice (job-PE requests, match-PE responses).
- Free-slot search reuses rr_arbiter, with the free vector as req.

Test Plan:
1. Reset, then job PE 2 sends tag 0x11, head 0x100, hist 0x40, all i_mreq_ready=0 -> next cycle o_mreq_valid=0001, slot0 holds id 2, tag 0x11.
2. All 4 job PEs valid every cycle, i_mreq_ready=1 -> grants rotate 0,1,2,3,0; targets rotate 0,1,2,3; one accept per cycle, no bubbles.
3. i_mreq_ready=0, 5 requests offered -> 4 accepted, o_req_ready=0 thereafter; one ready pulse frees exactly one slot and accepts exactly one request.
4. Match PEs 1 and 3 both respond to job PE 0 (len 8, len 3), i_resp_ready=0 -> only one accepted; the other is held with o_mresp_ready=0 until slot0 drains.
5. Match PE 0 responds to blocked job PE 1 while match PE 2 responds to free job PE 3 -> PE 2 is accepted the same cycle.
6. Assert rst with all slots full -> next cycle all valids 0; with MATCH_DISPATCH_STATS_EN defined, counters read 0.
